ttt_ai_move_sched: RTL and testbench

- Sequencer that services the game FSM's AI move request (ai_confirm).
- On each request it snapshots the 18-bit board, scans the 8 winning lines one per cycle, and returns one legal cell index on ai_tick with a one-cycle ai_ack pulse.
- Move priority: win, then block, then positional pick.
- Sits between game_fsm and the board register. It is the only producer of ai_tick/ai_ack.

---
 rtl/ttt_pkg.sv | 60 ++++++
 rtl/ttt_line_eval.sv | 47 ++++
 rtl/ttt_ai_move_sched.sv | 155 +++++++++++++++
 tb/tb_ttt_ai_move_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe AI move sequencer.
//   - cell encodings for the 2-bit board cells
//   - winning-line table (8 lines x 3 cell indices)
//   - positional pick priority order
//   - sequencer state encoding and the "no move" marker
//   - cell_at(): extracts one cell from the 18-bit board
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_AI     = 2'b10;

    localparam logic [3:0] NO_MOVE = 4'hF;

    // Each line is {c2, c1, c0}; lines are {line7, ..., line0}.
    // 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
    localparam logic [7:0][2:0][3:0] LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

    // Positional preference: centre, corners, then edges. Element 0 is tried first.
    localparam logic [8:0][3:0] PICK_ORDER = {
        4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
    };

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCAN_WIN   = 3'd1,
        ST_SCAN_BLOCK = 3'd2,
        ST_PICK       = 3'd3,
        ST_RESPOND    = 3'd4,
        ST_WAIT_DROP  = 3'd5
    } ttt_state_e;

    // Indices outside 0..8 read as occupied so they can never be chosen.
    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        logic [1:0] c;
        case (idx)
            4'd0:    c = board[1:0];
            4'd1:    c = board[3:2];
            4'd2:    c = board[5:4];
            4'd3:    c = board[7:6];
            4'd4:    c = board[9:8];
            4'd5:    c = board[11:10];
            4'd6:    c = board[13:12];
            4'd7:    c = board[15:14];
            4'd8:    c = board[17:16];
            default: c = 2'b11;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: combinational check of one winning line.
//   c0_i..c2_i   : the three 2-bit cells of the line
//   i0_i..i2_i   : their board indices
//   mark_i       : mark being looked for (CELL_AI or CELL_PLAYER)
//   hit_o        : exactly two cells equal mark_i and the third is empty
//   empty_idx_o  : index of the empty cell when hit_o, else NO_MOVE
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] c0_i,
    input  logic [1:0] c1_i,
    input  logic [1:0] c2_i,
    input  logic [3:0] i0_i,
    input  logic [3:0] i1_i,
    input  logic [3:0] i2_i,
    input  logic [1:0] mark_i,
    output logic       hit_o,
    output logic [3:0] empty_idx_o
);

    logic m0, m1, m2;
    logic e0, e1, e2;

    // Encoding 11 matches neither a mark nor empty, so it blocks a hit.
    assign m0 = (c0_i == mark_i);
    assign m1 = (c1_i == mark_i);
    assign m2 = (c2_i == mark_i);
    assign e0 = (c0_i == CELL_EMPTY);
    assign e1 = (c1_i == CELL_EMPTY);
    assign e2 = (c2_i == CELL_EMPTY);

    always_comb begin
        hit_o       = 1'b0;
        empty_idx_o = NO_MOVE;
        if (e0 && m1 && m2) begin
            hit_o       = 1'b1;
            empty_idx_o = i0_i;
        end else if (m0 && e1 && m2) begin
            hit_o       = 1'b1;
            empty_idx_o = i1_i;
        end else if (m0 && m1 && e2) begin
            hit_o       = 1'b1;
            empty_idx_o = i2_i;
        end
    end

endmodule

// File: rtl/ttt_ai_move_sched.sv
// ttt_ai_move_sched: services the game FSM's AI move request.
// On a request the board is snapshotted, the 8 lines are scanned one per
// cycle for a win (AI mark) then a block (player mark), falling back to a
// positional pick; the chosen cell is returned with a one-cycle ack.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   ai_confirm     : request level, held high until ack is seen
//   cell_position  : 18-bit board, cell i at [2i+1:2i]
//   ai_tick        : chosen cell 0..8, NO_MOVE if board full
//   ai_ack         : one-cycle pulse, ai_tick valid in that cycle
//   ai_busy        : high in any state except IDLE and WAIT_DROP
//   ai_nomove      : high with ai_ack when no move exists; held until next request
//   dbg_state      : current sequencer state
// Handshake: a request is a rising level on ai_confirm; the block answers with
// exactly one ai_ack pulse and then waits for ai_confirm to go low before it
// accepts another request. Dropping ai_confirm before the ack aborts silently.
module ttt_ai_move_sched
    import ttt_pkg::*;
#(
    parameter int LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ai_confirm,
    input  logic [17:0] cell_position,
    output logic [3:0]  ai_tick,
    output logic        ai_ack,
    output logic        ai_busy,
    output logic        ai_nomove,
    output ttt_state_e  dbg_state
);

    ttt_state_e  state_q, state_d;
    logic [17:0] snap_q, snap_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  tick_q, tick_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        nomove_q, nomove_d;

    logic [1:0]  mark;
    logic        hit;
    logic [3:0]  hit_idx;
    logic [3:0]  pick_idx;

    assign mark = (state_q == ST_SCAN_WIN) ? CELL_AI : CELL_PLAYER;

    ttt_line_eval u_line_eval (
        .c0_i        (cell_at(snap_q, LINES[idx_q][0])),
        .c1_i        (cell_at(snap_q, LINES[idx_q][1])),
        .c2_i        (cell_at(snap_q, LINES[idx_q][2])),
        .i0_i        (LINES[idx_q][0]),
        .i1_i        (LINES[idx_q][1]),
        .i2_i        (LINES[idx_q][2]),
        .mark_i      (mark),
        .hit_o       (hit),
        .empty_idx_o (hit_idx)
    );

    // Walk the priority list backwards so the earliest empty entry wins.
    always_comb begin
        pick_idx = NO_MOVE;
        for (int i = 8; i >= 0; i--) begin
            if (cell_at(snap_q, PICK_ORDER[i]) == CELL_EMPTY) begin
                pick_idx = PICK_ORDER[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        cand_d   = cand_q;
        tick_d   = tick_q;
        ack_d    = 1'b0;
        nomove_d = nomove_q;

        case (state_q)
            ST_IDLE: begin
                if (ai_confirm) begin
                    snap_d   = cell_position;
                    nomove_d = 1'b0;
                    idx_d    = 3'd0;
                    if (LEVEL >= 2)      state_d = ST_SCAN_WIN;
                    else if (LEVEL == 1) state_d = ST_SCAN_BLOCK;
                    else                 state_d = ST_PICK;
                end
            end
            ST_SCAN_WIN, ST_SCAN_BLOCK: begin
                if (!ai_confirm) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    cand_d  = hit_idx;
                    state_d = ST_RESPOND;
                end else if (idx_q == 3'd7) begin
                    idx_d   = 3'd0;
                    state_d = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PICK;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_PICK: begin
                if (!ai_confirm) begin
                    state_d = ST_IDLE;
                end else begin
                    cand_d  = pick_idx;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                ack_d    = 1'b1;
                tick_d   = cand_q;
                nomove_d = (cand_q == NO_MOVE);
                state_d  = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!ai_confirm) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT_DROP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            idx_q    <= '0;
            cand_q   <= '0;
            tick_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            nomove_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            cand_q   <= cand_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            nomove_q <= nomove_d;
        end
    end

    assign ai_tick   = tick_q;
    assign ai_ack    = ack_q;
    assign ai_busy   = busy_q;
    assign ai_nomove = nomove_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ttt_ai_move_sched.sv
module tb_ttt_ai_move_sched;
    import ttt_pkg::*;

    logic        clk;
    logic        rst;
    logic        ai_confirm;
    logic [17:0] cell_position;

    logic [3:0]  tick2, tick0;
    logic        ack2, ack0;
    logic        busy2, busy0;
    logic        nomove2, nomove0;
    ttt_state_e  st2, st0;

    int tests;
    int fails;

    // results of the last do_req call
    int         a2_cyc, a2_cnt, a0_cyc, a0_cnt;
    logic [3:0] t2_at_ack, t0_at_ack;
    logic       n2_at_ack;
    logic       busy_c3, busy_after_drop, nomove_c0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ttt_ai_move_sched #(.LEVEL(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .ai_confirm    (ai_confirm),
        .cell_position (cell_position),
        .ai_tick       (tick2),
        .ai_ack        (ack2),
        .ai_busy       (busy2),
        .ai_nomove     (nomove2),
        .dbg_state     (st2)
    );

    ttt_ai_move_sched #(.LEVEL(0)) dut0 (
        .clk           (clk),
        .rst           (rst),
        .ai_confirm    (ai_confirm),
        .cell_position (cell_position),
        .ai_tick       (tick0),
        .ai_ack        (ack0),
        .ai_busy       (busy0),
        .ai_nomove     (nomove0),
        .dbg_state     (st0)
    );

    // ---------------- helpers ----------------
    function automatic logic [17:0] bd(input int c0, input int c1, input int c2,
                                       input int c3, input int c4, input int c5,
                                       input int c6, input int c7, input int c8);
        logic [17:0] b;
        b = {c8[1:0], c7[1:0], c6[1:0], c5[1:0], c4[1:0], c3[1:0], c2[1:0], c1[1:0], c0[1:0]};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise a request on board b; cycle 0 is the first edge that sees it.
    // b_mid replaces the board after cycle 3. drop_at >= 0 lowers ai_confirm
    // so that edge drop_at samples it low. Ends with ai_confirm low.
    task automatic do_req(input logic [17:0] b, input logic [17:0] b_mid,
                          input int drop_at, input int ncyc);
        a2_cyc = -1; a2_cnt = 0; a0_cyc = -1; a0_cnt = 0;
        t2_at_ack = 4'h0; t0_at_ack = 4'h0; n2_at_ack = 1'b0;
        busy_c3 = 1'b0; busy_after_drop = 1'b1; nomove_c0 = 1'b1;
        @(negedge clk);
        cell_position = b;
        ai_confirm    = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (ack2) begin
                if (a2_cyc < 0) begin
                    a2_cyc    = c;
                    t2_at_ack = tick2;
                    n2_at_ack = nomove2;
                end
                a2_cnt++;
            end
            if (ack0) begin
                if (a0_cyc < 0) begin
                    a0_cyc    = c;
                    t0_at_ack = tick0;
                end
                a0_cnt++;
            end
            if (c == 0) nomove_c0 = nomove2;
            if (c == 3) begin
                busy_c3       = busy2;
                cell_position = b_mid;
            end
            if (drop_at >= 0 && c == drop_at + 1) busy_after_drop = busy2;
            if (c + 1 == drop_at) ai_confirm = 1'b0;
        end
        @(negedge clk);
        ai_confirm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    logic [17:0] b1, b2, bmulti, bfull, b11;
    int          acks;

    initial begin
        tests = 0;
        fails = 0;
        rst           = 1'b0;
        ai_confirm    = 1'b0;
        cell_position = '0;

        b1     = bd(2, 2, 0, 1, 1, 0, 0, 0, 0);
        b2     = bd(1, 2, 0, 0, 1, 0, 0, 0, 0);
        bmulti = bd(0, 0, 0, 2, 2, 0, 2, 2, 0);
        bfull  = bd(1, 2, 1, 2, 1, 2, 2, 1, 3);
        b11    = bd(3, 3, 0, 0, 3, 0, 0, 0, 3);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tick",   {28'd0, tick2},   32'd0);
        chk("reset_ack",    {31'd0, ack2},    32'd0);
        chk("reset_busy",   {31'd0, busy2},   32'd0);
        chk("reset_nomove", {31'd0, nomove2}, 32'd0);
        chk("reset_state",  {29'd0, st2},     {29'd0, ST_IDLE});
        @(negedge clk);
        rst = 1'b1;

        // 1: win on line 0 beats block on line 1
        do_req(b1, b1, -1, 30);
        chk("t1_ack_cyc", a2_cyc, 32'd2);
        chk("t1_tick",    {28'd0, t2_at_ack}, 32'd2);
        chk("t1_ack_cnt", a2_cnt, 32'd1);
        chk("t1_busy_c3", {31'd0, busy_c3}, 32'd0);

        // 2: block on line 6; board changed mid-scan is ignored
        do_req(b2, b1, -1, 30);
        chk("t2_ack_cyc", a2_cyc, 32'd16);
        chk("t2_tick",    {28'd0, t2_at_ack}, 32'd8);
        chk("t2_nomove",  {31'd0, n2_at_ack}, 32'd0);
        chk("t2_busy_c3", {31'd0, busy_c3}, 32'd1);

        // several wins: lowest line index (row 1 -> cell 5)
        do_req(bmulti, bmulti, -1, 30);
        chk("multi_ack_cyc", a2_cyc, 32'd3);
        chk("multi_tick",    {28'd0, t2_at_ack}, 32'd5);

        // 3: empty board, both levels
        do_req('0, '0, -1, 30);
        chk("t3_ack_cyc",   a2_cyc, 32'd18);
        chk("t3_tick",      {28'd0, t2_at_ack}, 32'd4);
        chk("t3_l0_ack_cyc", a0_cyc, 32'd2);
        chk("t3_l0_tick",   {28'd0, t0_at_ack}, 32'd4);

        // cells encoded 11 are neither marks nor candidates
        do_req(b11, b11, -1, 30);
        chk("b11_ack_cyc", a2_cyc, 32'd18);
        chk("b11_tick",    {28'd0, t2_at_ack}, 32'd2);

        // 4: full board
        do_req(bfull, bfull, -1, 30);
        chk("t4_ack_cyc",  a2_cyc, 32'd18);
        chk("t4_tick",     {28'd0, t2_at_ack}, 32'hF);
        chk("t4_nomove",   {31'd0, n2_at_ack}, 32'd1);
        chk("t4_hold_tick",   {28'd0, tick2},   32'hF);
        chk("t4_hold_nomove", {31'd0, nomove2}, 32'd1);
        chk("t4_l0_tick",  {28'd0, t0_at_ack}, 32'hF);

        // 5: abort at cycle 5; nomove clears on capture, tick held
        do_req('0, '0, 5, 30);
        chk("t5_nomove_clr", {31'd0, nomove_c0}, 32'd0);
        chk("t5_no_ack",     a2_cnt, 32'd0);
        chk("t5_busy_c6",    {31'd0, busy_after_drop}, 32'd0);
        chk("t5_tick_held",  {28'd0, tick2}, 32'hF);
        chk("t5_state",      {29'd0, st2}, {29'd0, ST_IDLE});
        do_req(b1, b1, -1, 30);
        chk("t5_fresh_cyc",  a2_cyc, 32'd2);
        chk("t5_fresh_tick", {28'd0, t2_at_ack}, 32'd2);

        // 6a: asynchronous reset mid-scan
        @(negedge clk);
        cell_position = '0;
        ai_confirm    = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_busy_before", {31'd0, busy2}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_tick",   {28'd0, tick2},   32'd0);
        chk("t6_rst_ack",    {31'd0, ack2},    32'd0);
        chk("t6_rst_busy",   {31'd0, busy2},   32'd0);
        chk("t6_rst_nomove", {31'd0, nomove2}, 32'd0);
        chk("t6_rst_state",  {29'd0, st2},     {29'd0, ST_IDLE});

        // 6b: ai_confirm held high over two scan lengths -> one ack only
        @(negedge clk);
        rst  = 1'b1;
        acks = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (ack2) acks++;
        end
        chk("t6_single_ack", acks, 32'd1);
        chk("t6_wait_state", {29'd0, st2}, {29'd0, ST_WAIT_DROP});
        chk("t6_tick",       {28'd0, tick2}, 32'd4);
        @(negedge clk);
        ai_confirm = 1'b0;
        repeat (2) @(negedge clk);
        do_req('0, '0, -1, 30);
        chk("t6_reack_cyc", a2_cyc, 32'd18);
        chk("t6_reack_cnt", a2_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
